// File: rtl/ram8_arb_pkg.sv
// ram8_arb_pkg
// Shared definitions for the RAM8 two-requester access controller:
//   - state_t       : controller FSM encoding (ST_INIT, ST_IDLE, ST_ACCESS)
//   - DATA_WIDTH_DEF: default word width of the RAM8 block
//   - ADDR_WIDTH_DEF: default word address width of the RAM8 block
//   - RAM_DEPTH     : number of RAM8 words, walked by the clear sequence
package ram8_arb_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int RAM_DEPTH      = 8;

  // ST_INIT is only ever entered when the clear-on-reset feature is built in.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/ram8_arbiter_rr.sv
// rr_arbiter2
// Two-way round-robin grant logic, purely combinational.
// Ports:
//   i_valid[1:0]  : request valid per requester
//   i_last_grant  : id of the requester granted most recently
//   i_enable      : grants are only issued while high
//   o_grant[1:0]  : one-hot (or zero) grant vector
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // On a tie the requester that was not granted last wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
// Arbitrates two valid/ready requesters round-robin onto a single RAM8
// block and returns read data (or the pre-write word for writes) as a
// one-cycle response pulse two cycles after the transfer.
// Optional feature: define RAM8_ARB_CLEAR_EN to zero all RAM8 words in an
// INIT sequence after every reset.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_reqN_valid/write/addr/wdata, o_reqN_ready : request port N (N=0,1)
//   o_rspN_valid, o_rspN_rdata  : response port N
//   o_ram_in, o_ram_addr, o_ram_load, i_ram_out : RAM8 pins
//   o_busy                      : high whenever the FSM is not IDLE
module ram8_arbiter
  import ram8_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
  output logic [DATA_WIDTH-1:0] o_ram_in,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_load,
  input  logic [DATA_WIDTH-1:0] i_ram_out,
  output logic                  o_busy
);

`ifdef RAM8_ARB_CLEAR_EN
  localparam state_t                RESET_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = ADDR_WIDTH'(RAM_DEPTH - 1);
  logic [ADDR_WIDTH-1:0] r_init_cnt;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_cmd_id;
  logic                  r_cmd_write;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wdata;
  logic                  r_rsp0_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;
  logic [1:0]            w_grant;
  logic                  w_arb_enable;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_xfer;

  // Grants only in IDLE; masking with reset keeps a transfer from being
  // accepted on the same edge that reset throws the state away.
  assign w_arb_enable = (r_state == ST_IDLE) & ~i_reset;

  rr_arbiter2 u_rr (
    .i_valid      ({i_req1_valid, i_req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (w_arb_enable),
    .o_grant      (w_grant)
  );

  assign o_req0_ready = w_grant[0];
  assign o_req1_ready = w_grant[1];
  assign w_xfer0      = i_req0_valid & w_grant[0];
  assign w_xfer1      = i_req1_valid & w_grant[1];
  assign w_xfer       = w_xfer0 | w_xfer1;

  assign o_busy       = (r_state != ST_IDLE);
  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp0_rdata = r_rsp0_rdata;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp1_rdata = r_rsp1_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus the RAM pin drive. ram_load is gated by reset so a
  // write in flight when reset arrives never reaches the RAM.
  always_comb begin
    w_next_state = r_state;
    o_ram_load   = 1'b0;
    o_ram_addr   = r_cmd_addr;
    o_ram_in     = r_cmd_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_ram_load   = r_cmd_write & ~i_reset;
        w_next_state = ST_IDLE;
      end
      ST_INIT: begin
`ifdef RAM8_ARB_CLEAR_EN
        o_ram_load = ~i_reset;
        o_ram_addr = r_init_cnt;
        o_ram_in   = '0;
        if (r_init_cnt == INIT_LAST) begin
          w_next_state = ST_IDLE;
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

`ifdef RAM8_ARB_CLEAR_EN
  // Walks every RAM8 word once; any reset restarts the walk at word 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end
`endif

  // Command register and round-robin history; both change only on a transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_cmd_id     <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
    end else if (w_xfer) begin
      r_last_grant <= w_xfer1;
      r_cmd_id     <= w_xfer1;
      r_cmd_write  <= w_xfer1 ? i_req1_write : i_req0_write;
      r_cmd_addr   <= w_xfer1 ? i_req1_addr  : i_req0_addr;
      r_cmd_wdata  <= w_xfer1 ? i_req1_wdata : i_req0_wdata;
    end
  end

  // ram_out is sampled during ACCESS before the RAM edge, so writes report
  // the word that was overwritten.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= (r_state == ST_ACCESS) && !r_cmd_id;
      r_rsp1_valid <= (r_state == ST_ACCESS) &&  r_cmd_id;
      if ((r_state == ST_ACCESS) && !r_cmd_id) begin
        r_rsp0_rdata <= i_ram_out;
      end
      if ((r_state == ST_ACCESS) && r_cmd_id) begin
        r_rsp1_rdata <= i_ram_out;
      end
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter
// Directed bench for ram8_arbiter with a behavioural RAM8 on the ram_* pins.
// Builds with or without RAM8_ARB_CLEAR_EN; the clear sequence is checked
// only when the macro is defined.
module tb_ram8_arbiter;

  logic        clk;
  logic        reset;
  logic        req0Valid, req0Write, req1Valid, req1Write;
  logic [2:0]  req0Addr, req1Addr;
  logic [15:0] req0Wdata, req1Wdata;
  logic        req0Ready, req1Ready;
  logic        rsp0Valid, rsp1Valid;
  logic [15:0] rsp0Rdata, rsp1Rdata;
  logic [15:0] ramIn, ramOut;
  logic [2:0]  ramAddr;
  logic        ramLoad;
  logic        busy;

  logic [15:0] mem [8];
  logic        tbWe;
  logic [2:0]  tbAddr;
  logic [15:0] tbData;

  int testCount = 0;
  int failCount = 0;

  ram8_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req0_valid (req0Valid),
    .i_req0_write (req0Write),
    .i_req0_addr  (req0Addr),
    .i_req0_wdata (req0Wdata),
    .o_req0_ready (req0Ready),
    .i_req1_valid (req1Valid),
    .i_req1_write (req1Write),
    .i_req1_addr  (req1Addr),
    .i_req1_wdata (req1Wdata),
    .o_req1_ready (req1Ready),
    .o_rsp0_valid (rsp0Valid),
    .o_rsp0_rdata (rsp0Rdata),
    .o_rsp1_valid (rsp1Valid),
    .o_rsp1_rdata (rsp1Rdata),
    .o_ram_in     (ramIn),
    .o_ram_addr   (ramAddr),
    .o_ram_load   (ramLoad),
    .i_ram_out    (ramOut),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8 model: combinational read, write on the rising edge. The bench
  // port has priority so words can be preloaded while the DUT is quiet.
  assign ramOut = mem[ramAddr];
  always @(posedge clk) begin
    if (tbWe) begin
      mem[tbAddr] <= tbData;
    end else if (ramLoad) begin
      mem[ramAddr] <= ramIn;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic w0, input logic [2:0] a0,
                               input logic [15:0] d0, input logic v1, input logic w1,
                               input logic [2:0] a1, input logic [15:0] d1);
    req0Valid = v0; req0Write = w0; req0Addr = a0; req0Wdata = d0;
    req1Valid = v1; req1Write = w1; req1Addr = a1; req1Wdata = d1;
  endtask

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    tbWe = 1'b1; tbAddr = addr; tbData = data;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

`ifdef RAM8_ARB_CLEAR_EN
  // Called #1 after reset deasserts: expects eight clear cycles, with both
  // requesters knocking and never being let in.
  task automatic runInit();
    applyStimulus(1, 0, 3'd0, 16'h0, 1, 0, 3'd0, 16'h0);
    #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("init%0d.load", k), ramLoad, 1'b1);
      checkOutput($sformatf("init%0d.addr", k), ramAddr, k);
      checkOutput($sformatf("init%0d.in", k), ramIn, 16'h0);
      checkOutput($sformatf("init%0d.busy", k), busy, 1'b1);
      checkOutput($sformatf("init%0d.ready", k), {req1Ready, req0Ready}, 2'b00);
      @(negedge clk);
      #1;
    end
    checkOutput("init.done.busy", busy, 1'b0);
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
  endtask
`endif

  task automatic finishReset();
    checkOutput("rst.rsp0Valid", rsp0Valid, 1'b0);
    checkOutput("rst.rsp1Valid", rsp1Valid, 1'b0);
    checkOutput("rst.rsp0Rdata", rsp0Rdata, 16'h0);
    checkOutput("rst.rsp1Rdata", rsp1Rdata, 16'h0);
    checkOutput("rst.ramAddr", ramAddr, 3'd0);
    checkOutput("rst.ramIn", ramIn, 16'h0);
`ifdef RAM8_ARB_CLEAR_EN
    runInit();
`else
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.ramLoad", ramLoad, 1'b0);
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    finishReset();
  endtask

  // One isolated access by requester id, checked through to its response.
  task automatic runAccess(input int id, input logic wr, input logic [2:0] addr,
                           input logic [15:0] wd, input logic [15:0] expR,
                           input string tag);
    @(negedge clk);
    if (id == 0) applyStimulus(1, wr, addr, wd, 0, 0, 3'd0, 16'h0);
    else         applyStimulus(0, 0, 3'd0, 16'h0, 1, wr, addr, wd);
    #1;
    checkOutput({tag, ".ready"}, {req1Ready, req0Ready}, (id == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    #1;
    checkOutput({tag, ".busy"}, busy, 1'b1);
    checkOutput({tag, ".load"}, ramLoad, wr);
    checkOutput({tag, ".addr"}, ramAddr, addr);
    if (wr) checkOutput({tag, ".in"}, ramIn, wd);
    @(negedge clk);
    #1;
    checkOutput({tag, ".rspValid"}, {rsp1Valid, rsp0Valid}, (id == 0) ? 2'b01 : 2'b10);
    checkOutput({tag, ".rdata"}, (id == 0) ? rsp0Rdata : rsp1Rdata, expR);
    checkOutput({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tbWe = 1'b0; tbAddr = 3'd0; tbData = 16'h0;
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    for (int k = 0; k < 8; k++) preload(3'(k), 16'h0);
    doReset();

    // Single write then read of the same word.
    runAccess(0, 1'b1, 3'd5, 16'hBEEF, 16'h0000, "wr5");
    checkOutput("wr5.mem", mem[5], 16'hBEEF);
    runAccess(0, 1'b0, 3'd5, 16'h0000, 16'hBEEF, "rd5");

    // Tie from reset: grants alternate 0,1,0,1 and only reach the winner.
    preload(3'd1, 16'h1111);
    preload(3'd2, 16'h2222);
    doReset();
    @(negedge clk);
    applyStimulus(1, 0, 3'd1, 16'h0, 1, 0, 3'd2, 16'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d.grant", i), {req1Ready, req0Ready},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr%0d.onehot", i), req0Ready & req1Ready, 1'b0);
      @(negedge clk);
      #1;
      checkOutput($sformatf("rr%0d.addr", i), ramAddr, (i % 2 == 0) ? 3'd1 : 3'd2);
      checkOutput($sformatf("rr%0d.noready", i), {req1Ready, req0Ready}, 2'b00);
      @(negedge clk);
      #1;
      checkOutput($sformatf("rr%0d.rsp", i), {rsp1Valid, rsp0Valid},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr%0d.rdata", i), (i % 2 == 0) ? rsp0Rdata : rsp1Rdata,
                  (i % 2 == 0) ? 16'h1111 : 16'h2222);
    end
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);

    // Back-to-back read-after-write on requester 1, valid held throughout.
    @(negedge clk);
    applyStimulus(0, 0, 3'd0, 16'h0, 1, 1, 3'd7, 16'h1234);
    #1;
    checkOutput("raw.wrReady", req1Ready, 1'b1);
    @(negedge clk);
    applyStimulus(0, 0, 3'd0, 16'h0, 1, 0, 3'd7, 16'h0);
    #1;
    checkOutput("raw.wrLoad", ramLoad, 1'b1);
    checkOutput("raw.wrIn", ramIn, 16'h1234);
    @(negedge clk);
    #1;
    checkOutput("raw.wrRsp", rsp1Valid, 1'b1);
    checkOutput("raw.wrOld", rsp1Rdata, 16'h0000);
    checkOutput("raw.rdReady", req1Ready, 1'b1);
    @(negedge clk);
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    #1;
    checkOutput("raw.rdLoad", ramLoad, 1'b0);
    checkOutput("raw.rdAddr", ramAddr, 3'd7);
    @(negedge clk);
    #1;
    checkOutput("raw.rdRsp", rsp1Valid, 1'b1);
    checkOutput("raw.rdData", rsp1Rdata, 16'h1234);

    // Reset during a write's ACCESS cycle.
    @(negedge clk);
    applyStimulus(1, 1, 3'd2, 16'hFFFF, 0, 0, 3'd0, 16'h0);
    #1;
    checkOutput("rstAcc.ready", req0Ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    #1;
    checkOutput("rstAcc.load", ramLoad, 1'b0);
    checkOutput("rstAcc.busy", busy, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("rstAcc.mem2", mem[2], 16'h2222);
    checkOutput("rstAcc.rsp", {rsp1Valid, rsp0Valid}, 2'b00);
    reset = 1'b0;
    #1;
    finishReset();
    @(negedge clk);
    #1;
    checkOutput("rstAcc.norsp", {rsp1Valid, rsp0Valid}, 2'b00);
    checkOutput("rstAcc.mem2Later", mem[2], 16'h2222);

`ifdef RAM8_ARB_CLEAR_EN
    // Clear sequence with a restart partway through, then all words read 0.
    for (int k = 0; k < 8; k++) preload(3'(k), 16'hA000 + 16'(k));
    checkOutput("clr.preload", mem[3], 16'hA003);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("clrPre%0d.addr", k), ramAddr, k);
      @(negedge clk);
      #1;
    end
    checkOutput("clrPre4.addr", ramAddr, 3'd4);
    reset = 1'b1;
    #1;
    checkOutput("clrRst.load", ramLoad, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    runInit();
    for (int k = 0; k < 8; k++) begin
      runAccess(k % 2, 1'b0, 3'(k), 16'h0, 16'h0, $sformatf("clrRd%0d", k));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
